// File: rtl/sm_pkg.sv
// Shared constants and FSM encoding for the sm_sync front-end aligner.
package sm_pkg;
  localparam int NCH = 8;
  localparam int DW  = 16;
  localparam int TW  = 16;

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
endpackage

// File: rtl/sm_sync_if.sv
// Channel-in / frame-out bundle between the sensor side and sm_sync.
interface sm_sync_if #(parameter int DW = sm_pkg::DW);
  logic [DW-1:0] ch1_data, ch2_data, ch3_data, ch4_data;
  logic [DW-1:0] ch5_data, ch6_data, ch7_data, ch8_data;
  logic [7:0]    ch_vld;

  logic [DW-1:0] sm1_data, sm2_data, sm3_data, sm4_data;
  logic [DW-1:0] sm5_data, sm6_data, sm7_data, sm8_data;
  logic          sm_vld;
  logic [7:0]    sm_miss;

  modport master (
    output ch1_data, ch2_data, ch3_data, ch4_data,
           ch5_data, ch6_data, ch7_data, ch8_data, ch_vld,
    input  sm1_data, sm2_data, sm3_data, sm4_data,
           sm5_data, sm6_data, sm7_data, sm8_data, sm_vld, sm_miss
  );

  modport slave (
    input  ch1_data, ch2_data, ch3_data, ch4_data,
           ch5_data, ch6_data, ch7_data, ch8_data, ch_vld,
    output sm1_data, sm2_data, sm3_data, sm4_data,
           sm5_data, sm6_data, sm7_data, sm8_data, sm_vld, sm_miss
  );
endinterface

// File: rtl/sm_sync_ch.sv
// One channel slot: capture register plus the got bit for the current frame.
module sm_sync_ch #(
  parameter int DW = 16
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          vld,
  input  logic          clr,
  input  logic [DW-1:0] sample,
  output logic [DW-1:0] data,
  output logic          got,
  output logic          dup
);

  // The capture register survives frame boundaries so a missing channel
  // re-emits its last value; only got is cleared when the frame closes.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      got  <= 1'b0;
    end else begin
      if (vld)
        data <= sample;
      if (clr)
        got <= 1'b0;
      else if (vld)
        got <= 1'b1;
    end
  end

  assign dup = vld & got;

endmodule

// File: rtl/sm_sync.sv
// Collects one sample per channel into a frame and emits all eight in parallel,
// closing early on a microsecond timeout when a channel goes quiet.
module sm_sync
  import sm_pkg::*;
#(
  parameter int DW = sm_pkg::DW,
  parameter int TW = sm_pkg::TW
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          pluse_us,
  input  logic [TW-1:0] cfg_timeout_us,
  sm_sync_if.slave      bus,
  output logic          sm_ovr,
  output logic [7:0]    err_cnt
);

  logic [DW-1:0]  ch_data    [NCH];
  logic [DW-1:0]  cap        [NCH];
  logic [DW-1:0]  frame_data [NCH];
  logic [DW-1:0]  sm_data    [NCH];
  logic [NCH-1:0] vld, got, dup;
  logic [NCH-1:0] miss;
  logic [0:0]     state;
  logic [TW-1:0]  cnt, cnt_inc;
  logic           done, timeout, emit, sm_vld;

  assign vld        = bus.ch_vld;
  assign ch_data[0] = bus.ch1_data;
  assign ch_data[1] = bus.ch2_data;
  assign ch_data[2] = bus.ch3_data;
  assign ch_data[3] = bus.ch4_data;
  assign ch_data[4] = bus.ch5_data;
  assign ch_data[5] = bus.ch6_data;
  assign ch_data[6] = bus.ch7_data;
  assign ch_data[7] = bus.ch8_data;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sm_sync_ch #(.DW(DW)) u_ch (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .vld     (vld[i]),
      .clr     (emit),
      .sample  (ch_data[i]),
      .data    (cap[i]),
      .got     (got[i]),
      .dup     (dup[i])
    );
    assign frame_data[i] = vld[i] ? ch_data[i] : cap[i];
  end

  // Completion is blocked in the sm_vld cycle so frames are never back to back;
  // arrivals then simply open the next frame.
  assign cnt_inc = cnt + TW'(1);
  assign done    = ~sm_vld && ((got | vld) == {NCH{1'b1}});
  assign timeout = (state == COLLECT) && pluse_us &&
                   (cfg_timeout_us != '0) && (cnt_inc == cfg_timeout_us);
  assign emit    = done | timeout;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (emit)
        state <= IDLE;
      else if ((state == IDLE) && (|vld))
        state <= COLLECT;

      if ((state == IDLE) || emit)
        cnt <= '0;
      else if (pluse_us)
        cnt <= cnt_inc;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sm_vld  <= 1'b0;
      miss    <= '0;
      sm_ovr  <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i < NCH; i++)
        sm_data[i] <= '0;
    end else begin
      sm_vld <= emit;
      if (emit) begin
        miss <= done ? '0 : ~(got | vld);
        for (int i = 0; i < NCH; i++)
          sm_data[i] <= frame_data[i];
      end
      if (|dup)
        sm_ovr <= 1'b1;
      if (timeout && !done && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.sm_vld   = sm_vld;
  assign bus.sm_miss  = miss;
  assign bus.sm1_data = sm_data[0];
  assign bus.sm2_data = sm_data[1];
  assign bus.sm3_data = sm_data[2];
  assign bus.sm4_data = sm_data[3];
  assign bus.sm5_data = sm_data[4];
  assign bus.sm6_data = sm_data[5];
  assign bus.sm7_data = sm_data[6];
  assign bus.sm8_data = sm_data[7];

endmodule

// File: doc/sm_sync.md
Name: sm_sync

Overview:
- Front-end aligner that sits directly upstream of chip_top.
- Eight sensor channels deliver 16-bit samples, each with its own independent valid strobe.
- sm_sync collects one sample per channel into a frame, then presents all eight in parallel on sm1_data..sm8_data with a single-cycle sm_vld. This is the exact interface chip_top consumes.
- A microsecond timeout, counted from pluse_us, stops a dead channel from stalling the data path. Per-channel miss flags and an error counter report the fault.

Parameters:
- DW, 16, sample width; must match chip_top's 16-bit sm ports.
- TW, 16, width of the timeout counter and of cfg_timeout_us.

Ports:
- clk_sys  in  1  system clock; all logic is single-clock on this edge.
- rst_n  in  1  asynchronous active-low reset.
- pluse_us  in  1  one-clk_sys-cycle pulse, once per microsecond.
- chN_data (N=1..8)  in  DW  channel N sample; qualified by ch_vld[N-1].
- ch_vld  in  8  per-channel valid strobes; any combination may be set in one cycle.
- cfg_timeout_us  in  TW  frame timeout in us; 0 disables the timeout.
- smN_data (N=1..8)  out  DW  aligned frame samples, registered.
- sm_vld  out  1  one-cycle frame strobe.
- sm_miss  out  8  channels absent from the frame just emitted; valid with sm_vld, held until the next frame.
- sm_ovr  out  1  sticky flag: a channel delivered twice within one frame. Cleared by reset only.
- err_cnt  out  8  count of timed-out frames; saturates at 8'hFF.

Behaviour:
- Reset: all outputs are 0, capture registers are 0, got mask is 0, FSM is IDLE, timeout counter is 0.
- Capture:
  - When ch_vld[i] is set, chN_data is written into capture register i and got[i] is set.
  - Capture register i is written only on ch_vld[i]. It holds its value across frames.
- FSM has two states, IDLE and COLLECT.
- IDLE:
  - Any ch_vld bit captures the asserted channels and moves the FSM to COLLECT, with the timeout counter at 0.
  - If all 8 bits arrive in the same cycle, the frame completes immediately (see Emit).
- COLLECT:
  - The timeout counter increments on each pluse_us.
  - A channel whose got bit is already set and sees ch_vld again overwrites its capture register and sets sm_ovr. The frame continues.
- Emit on completion:
  - Completion means the got mask, OR'd with the current cycle's ch_vld, equals 8'hFF.
  - If the final channel is sampled in cycle t, then in cycle t+1: sm_vld=1, smN_data = captured values (including the cycle-t samples), sm_miss=0.
  - The FSM returns to IDLE and the got mask clears.
- Emit on timeout:
  - Timeout means cfg_timeout_us != 0 and the counter reaches cfg_timeout_us.
  - Next cycle: sm_vld=1 and sm_miss = ~got.
  - Missing channels output their last captured value (0 if never captured since reset).
  - err_cnt increments, saturating. Then IDLE, and the got mask clears.
- Simultaneous events:
  - Completion and timeout in the same cycle: completion wins, sm_miss=0, err_cnt unchanged.
- Arrivals in the emit cycle:
  - ch_vld seen during the sm_vld cycle belongs to the next frame.
  - Those channels are captured, their got bits are set, and the FSM enters COLLECT with the counter at 0.
- Changing cfg_timeout_us mid-frame takes effect immediately; the comparison is equality.
  - If the counter is already past the new value, the frame waits until completion or counter wrap.
  - The counter wraps at 2^TW.
- sm_vld is never asserted on two consecutive cycles.
  - Minimum frame spacing is 2 cycles, which happens when all channels arrive together every other cycle.
- Reset asserted mid-frame: the partial frame is discarded, nothing is emitted, and all registers return to reset values asynchronously.

Decomposition:
- Shared package sm_pkg:
  - constants NCH=8, DW, TW;
  - FSM state encoding (IDLE=1'b0, COLLECT=1'b1).
- Sub-module sm_sync_ch, instantiated 8 times:
  - one capture register plus one got bit;
  - inputs: vld, data, clr (frame-done);
  - outputs: data, got, dup (vld while got is set).
- sm_sync contains the FSM, timeout counter, emit register stage, sm_ovr and err_cnt.

Test Plan:
- Ideal frame: cfg_timeout_us=10; ch1..ch8 arrive one per cycle with data 16'h1111..16'h8888. Required: sm_vld one cycle after ch8, sm1..sm8 = 1111..8888, sm_miss=0, err_cnt=0.
- All-at-once frame: all 8 ch_vld bits in cycle t with data 16'hA0A0..16'hA7A7. Required: sm_vld at t+1 with those values. Repeat every 2 cycles: sm_vld at every 2nd cycle, with no gaps and no doubles.
- Timeout: cfg_timeout_us=5; only ch1..ch6 arrive. Required: sm_vld the cycle after the 5th pluse_us, sm_miss=8'hC0, sm7/sm8 hold their previous frame's values, err_cnt=1. Repeat 300 times: err_cnt saturates at 8'hFF.
- Duplicate channel: ch3 is sent twice (16'h0003, then 16'h0033) before ch8 completes the frame. Required: sm3_data=16'h0033, sm_ovr=1 and stays 1 through the next clean frame.
- Race and carry-over:
  - ch8 completes the frame in the same cycle the timeout hits. Required: sm_miss=0, err_cnt unchanged.
  - ch2 is asserted during the sm_vld cycle. Required: ch2 is counted in the next frame only.
- Reset mid-frame: pulse rst_n low after 4 channels have arrived. Required: no sm_vld, all outputs 0. A following full frame emits normally with sm_miss=0.
